// File: rtl/fa_serial_adder.sv
// rtl/fa_serial_adder.sv - bit-serial WIDTH-bit adder, LSB first; FA_SERIAL_SUB_EN adds a subtract mode
module fa_serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
`ifdef FA_SERIAL_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             co
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-2:0] r_sr;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic             fa_s;
    logic             fa_c;
    logic [WIDTH-1:0] r_next;
    logic [WIDTH-1:0] b_load;
    logic             c_load;

    // Full-adder cell on the current LSBs and the carry flip-flop
    assign fa_s   = a_sr[0] ^ b_sr[0] ^ carry;
    assign fa_c   = (a_sr[0] & b_sr[0]) | (carry & (a_sr[0] ^ b_sr[0]));
    assign r_next = {fa_s, r_sr};

    // Subtraction is a + ~b + 1, so only the load values differ
`ifdef FA_SERIAL_SUB_EN
    assign b_load = sub ? ~b : b;
    assign c_load = sub | ci;
`else
    assign b_load = b;
    assign c_load = ci;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            s     <= '0;
            co    <= 1'b0;
            a_sr  <= '0;
            b_sr  <= '0;
            r_sr  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= b_load;
                        carry <= c_load;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= SHIFT;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                SHIFT: begin
                    r_sr  <= r_next[WIDTH-1:1];
                    carry <= fa_c;
                    a_sr  <= {1'b0, a_sr[WIDTH-1:1]};
                    b_sr  <= {1'b0, b_sr[WIDTH-1:1]};
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        s     <= r_next;
                        co    <= fa_c;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
